// File: rtl/csr_pkg.sv
// csr_pkg: shared types and constants for the machine-mode CSR file.
//   csr_addr_t / word_t : CSR address and data widths
//   csr_op_t            : trap/return operation carried by the retiring instruction
//   excep_data_t        : exception-state record exchanged with decode/commit
//   MSTATUS_* / CAUSE_* : mstatus field positions and trap cause codes
package csr_pkg;

  typedef logic [11:0] csr_addr_t;
  typedef logic [63:0] word_t;

  localparam csr_addr_t CSR_MSTATUS  = 12'h300;
  localparam csr_addr_t CSR_MTVEC    = 12'h305;
  localparam csr_addr_t CSR_MSCRATCH = 12'h340;
  localparam csr_addr_t CSR_MEPC     = 12'h341;
  localparam csr_addr_t CSR_MCAUSE   = 12'h342;
  localparam csr_addr_t CSR_MTVAL    = 12'h343;
  localparam csr_addr_t CSR_MCYCLE   = 12'hB00;
  localparam csr_addr_t CSR_MINSTRET = 12'hB02;
  localparam csr_addr_t CSR_MHARTID  = 12'hF14;

  typedef enum logic [1:0] {
    CSR_OP_NONE   = 2'd0,
    CSR_OP_MRET   = 2'd1,
    CSR_OP_ECALL  = 2'd2,
    CSR_OP_EBREAK = 2'd3
  } csr_op_t;

  typedef struct packed {
    word_t   mstatus;
    word_t   mtvec;
    word_t   mepc;
    word_t   mcause;
    word_t   mtval;
    csr_op_t csrop;
  } excep_data_t;

  typedef enum logic {
    TRAP_IDLE     = 1'b0,
    TRAP_REDIRECT = 1'b1
  } trap_state_t;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  // Only MIE, MPIE and MPP are implemented; everything else reads 0.
  localparam word_t MSTATUS_WMASK = 64'h0000_0000_0000_1888;

  localparam word_t CAUSE_ECALL_M    = 64'd11;
  localparam word_t CAUSE_BREAKPOINT = 64'd3;

  function automatic word_t align4(input word_t v);
    return {v[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: IDLE/REDIRECT state machine, redirect latch and the
// trap-entry / trap-return next values for the trap CSRs.
//   clk, reset          : core clock, synchronous active-high reset
//   commit_valid/pc     : retiring instruction
//   csrop               : its trap/return operation
//   mstatus/mtvec/mepc  : current CSR state
//   idle                : FSM is accepting commits
//   trap_take           : a trap/return op commits this cycle
//   trap_entry          : that op is ECALL/EBREAK (updates mepc/mcause/mtval)
//   *_next              : values the CSRs take when trap_take is high
//   redirect_*          : PC-redirect handshake towards fetch
module csr_trap_unit
  import csr_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    commit_valid,
  input  word_t   commit_pc,
  input  csr_op_t csrop,
  input  word_t   mstatus,
  input  word_t   mtvec,
  input  word_t   mepc,
  output logic    idle,
  output logic    trap_take,
  output logic    trap_entry,
  output word_t   mstatus_next,
  output word_t   mepc_next,
  output word_t   mcause_next,
  output word_t   mtval_next,
  output logic    redirect_valid,
  output word_t   redirect_pc,
  input  logic    redirect_ready
);

  trap_state_t state;
  word_t       target;

  assign idle       = (state == TRAP_IDLE);
  assign trap_take  = idle && commit_valid && (csrop != CSR_OP_NONE);
  assign trap_entry = (csrop == CSR_OP_ECALL) || (csrop == CSR_OP_EBREAK);

  always_comb begin
    mstatus_next = mstatus;
    mepc_next    = align4(commit_pc);
    mcause_next  = CAUSE_ECALL_M;
    mtval_next   = '0;
    target       = mtvec;
    unique case (csrop)
      CSR_OP_ECALL, CSR_OP_EBREAK: begin
        mstatus_next[MSTATUS_MPIE]                  = mstatus[MSTATUS_MIE];
        mstatus_next[MSTATUS_MIE]                   = 1'b0;
        mstatus_next[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        if (csrop == CSR_OP_EBREAK) begin
          mcause_next = CAUSE_BREAKPOINT;
          mtval_next  = commit_pc;
        end
      end
      CSR_OP_MRET: begin
        mstatus_next[MSTATUS_MIE]                   = mstatus[MSTATUS_MPIE];
        mstatus_next[MSTATUS_MPIE]                  = 1'b1;
        mstatus_next[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
        target                                      = mepc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= TRAP_IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      unique case (state)
        TRAP_IDLE: begin
          if (trap_take) begin
            state          <= TRAP_REDIRECT;
            redirect_valid <= 1'b1;
            redirect_pc    <= target;
          end
        end
        TRAP_REDIRECT: begin
          if (redirect_ready) begin
            state          <= TRAP_IDLE;
            redirect_valid <= 1'b0;
          end
        end
        default: begin
          state          <= TRAP_IDLE;
          redirect_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR and trap-state file.
//   clk, reset         : core clock, synchronous active-high reset
//   csr_raddr/rdata    : combinational CSR read port (decode)
//   excep_rdata        : current mstatus/mtvec/mepc snapshot for decode
//   commit_*           : retiring instruction, CSR write and trap record
//   redirect_*         : trap/return PC redirect towards fetch
module csr_file
  import csr_pkg::*;
#(
  parameter word_t HARTID = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  csr_addr_t   csr_raddr,
  output word_t       csr_rdata,
  output excep_data_t excep_rdata,
  input  logic        commit_valid,
  input  word_t       commit_pc,
  input  logic        csr_we,
  input  csr_addr_t   csr_waddr,
  input  word_t       csr_wdata,
  input  excep_data_t excep_wdata,
  output logic        redirect_valid,
  output word_t       redirect_pc,
  input  logic        redirect_ready
);

  word_t mstatus, mtvec, mscratch, mepc, mcause, mtval, mcycle, minstret;

  logic  idle, trap_take, trap_entry;
  word_t mstatus_next, mepc_next, mcause_next, mtval_next;

  // Only the op field of the retiring record matters here.
  logic unused_excep;
  assign unused_excep = ^{excep_wdata.mstatus, excep_wdata.mtvec, excep_wdata.mepc,
                          excep_wdata.mcause, excep_wdata.mtval};

  csr_trap_unit u_trap (
    .clk            (clk),
    .reset          (reset),
    .commit_valid   (commit_valid),
    .commit_pc      (commit_pc),
    .csrop          (excep_wdata.csrop),
    .mstatus        (mstatus),
    .mtvec          (mtvec),
    .mepc           (mepc),
    .idle           (idle),
    .trap_take      (trap_take),
    .trap_entry     (trap_entry),
    .mstatus_next   (mstatus_next),
    .mepc_next      (mepc_next),
    .mcause_next    (mcause_next),
    .mtval_next     (mtval_next),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready)
  );

  // Later assignments win: a CSR write to a counter overrides its increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus  <= '0;
      mtvec    <= '0;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle <= mcycle + 64'd1;
      if (trap_take) begin
        mstatus <= mstatus_next;
        if (trap_entry) begin
          mepc   <= mepc_next;
          mcause <= mcause_next;
          mtval  <= mtval_next;
        end else begin
          minstret <= minstret + 64'd1;
        end
      end else if (idle && commit_valid) begin
        minstret <= minstret + 64'd1;
        if (csr_we) begin
          unique case (csr_waddr)
            CSR_MSTATUS:  mstatus  <= csr_wdata & MSTATUS_WMASK;
            CSR_MTVEC:    mtvec    <= align4(csr_wdata);
            CSR_MSCRATCH: mscratch <= csr_wdata;
            CSR_MEPC:     mepc     <= align4(csr_wdata);
            CSR_MCAUSE:   mcause   <= csr_wdata;
            CSR_MTVAL:    mtval    <= csr_wdata;
            CSR_MCYCLE:   mcycle   <= csr_wdata;
            CSR_MINSTRET: minstret <= csr_wdata;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    unique case (csr_raddr)
      CSR_MSTATUS:  csr_rdata = mstatus;
      CSR_MTVEC:    csr_rdata = mtvec;
      CSR_MSCRATCH: csr_rdata = mscratch;
      CSR_MEPC:     csr_rdata = mepc;
      CSR_MCAUSE:   csr_rdata = mcause;
      CSR_MTVAL:    csr_rdata = mtval;
      CSR_MCYCLE:   csr_rdata = mcycle;
      CSR_MINSTRET: csr_rdata = minstret;
      CSR_MHARTID:  csr_rdata = HARTID;
      default:      csr_rdata = '0;
    endcase
  end

  always_comb begin
    excep_rdata         = '0;
    excep_rdata.mstatus = mstatus;
    excep_rdata.mtvec   = mtvec;
    excep_rdata.mepc    = mepc;
    excep_rdata.csrop   = CSR_OP_NONE;
  end

endmodule
